// File: rtl/gray_cnt_updn.sv
// Up/down Gray-code counter with sync clear, parallel load and wrap/saturate limits.
// Binary and Gray counts are registered together from the same next value, so they never skew.
module gray_cnt_updn #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned SAT_MODE = 0,
   parameter int unsigned INIT     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_bin,
   output logic [WIDTH-1:0] bin_cnt,
   output logic [WIDTH-1:0] gry_cnt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] INIT_BIN = INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_GRY = INIT_BIN ^ (INIT_BIN >> 1);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gry;
   logic             r_tc;

   logic             w_at_term;
   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gry_nxt;
   logic             w_tc_nxt;

   // Terminal value depends on direction: all-ones going up, zero going down.
   assign w_at_term = dir ? (r_bin == {WIDTH{1'b1}}) : (r_bin == '0);

   always_comb begin
      w_bin_nxt = r_bin;
      w_tc_nxt  = 1'b0;
      if (clr) begin
         w_bin_nxt = '0;
      end else if (ld) begin
         w_bin_nxt = ld_bin;
      end else if (en) begin
         w_tc_nxt = w_at_term;
         if (w_at_term && (SAT_MODE != 0)) begin
            w_bin_nxt = r_bin;
         end else if (dir) begin
            w_bin_nxt = r_bin + 1'b1;
         end else begin
            w_bin_nxt = r_bin - 1'b1;
         end
      end
   end

   assign w_gry_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin <= INIT_BIN;
         r_gry <= INIT_GRY;
         r_tc  <= 1'b0;
      end else begin
         r_bin <= w_bin_nxt;
         r_gry <= w_gry_nxt;
         r_tc  <= w_tc_nxt;
      end
   end

   assign bin_cnt = r_bin;
   assign gry_cnt = r_gry;
   assign tc      = r_tc;

endmodule

// File: doc/gray_cnt_updn.md
# gray_cnt_updn

Parametrised Gray-code counter with up/down direction, synchronous clear, parallel load and wrap/saturate modes. It holds registered binary and Gray counts that always describe the same value, plus a registered terminal-count pulse. It is the general-purpose successor to the fixed up-only Gray counter. Intended users are async-FIFO pointer logic, rotary/position trackers, and low-toggle address generators.

## Interface
- WIDTH, 4, counter width in bits; legal range ≥ 2
- SAT_MODE, 0, 0 = wrap at limits, 1 = saturate (hold) at limits
- INIT, 0, binary reset value; must be < 2^WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  count enable; one step per cycle while high
- dir  input  1  1 = count up, 0 = count down; sampled only when a step occurs
- clr  input  1  synchronous clear to binary 0
- ld  input  1  synchronous parallel load
- ld_bin  input  WIDTH  load value, binary-coded
- bin_cnt  output  WIDTH  registered binary count
- gry_cnt  output  WIDTH  registered Gray count; always equals bin_cnt ^ (bin_cnt >> 1)
- tc  output  1  registered terminal-count pulse

## Operation
- Reset (rst high, asynchronous): bin_cnt = INIT; gry_cnt = INIT ^ (INIT >> 1); tc = 0. All outputs hold while rst is high.
- Next-value priority, evaluated each cycle:
  - clr → 0
  - else ld → ld_bin
  - else en → step
  - else hold
- Step, up: MAX = 2^WIDTH − 1.
  - bin < MAX → bin + 1.
  - bin = MAX → 0 if SAT_MODE = 0, else MAX.
- Step, down:
  - bin > 0 → bin − 1.
  - bin = 0 → MAX if SAT_MODE = 0, else 0.
- Arithmetic is modulo 2^WIDTH. No carry or borrow is exposed.
- Gray output is computed from the next binary value and registered in the same edge as bin_cnt. The two outputs are never skewed, not even by one cycle.
- tc is set for exactly one cycle after an edge where a step was taken from the terminal value: MAX when counting up, 0 when counting down. This holds in both modes; in saturate mode tc repeats every cycle while en is held at the limit.
- clr or ld suppress tc, even if en is high at a terminal value.
- Gray property: every enabled step, including wrap, changes exactly one bit of gry_cnt. Saturate-hold changes no bits. clr and ld may change any number of bits.

## Timing
- Latency: inputs sampled at edge N appear on bin_cnt, gry_cnt and tc after edge N. There is no combinational path from any input to any output.
- A change of dir takes effect on the first step after it is sampled. Reversing direction produces the Gray predecessor or successor immediately, with no dead cycle.
- clr and ld both high: clr wins and the count becomes 0.
- ld with ld_bin = current value: no output bits change and tc = 0.
- rst asserted mid-count: outputs return to reset values immediately, without waiting for a clock edge. After rst deasserts, the first step applies at the first edge where en is high.
- en low: all registers hold and tc = 0 on the following cycle.

## Test plan
- WIDTH=4, SAT_MODE=0, INIT=0, en=1, dir=1 for 17 cycles → bin_cnt runs 0…15 then 0. gry_cnt runs 0000, 0001, 0011 … 1000 then 0000, with Hamming distance 1 at every step. tc = 1 only in the cycle after 15→0.
- Same configuration, dir=0 from reset → bin_cnt goes 15, 14, …; gry_cnt starts at 1000. tc pulses in the cycle after 0→15.
- SAT_MODE=1, ld_bin=14, ld=1 for one cycle, then en=1, dir=1 for 4 cycles → bin_cnt goes 14, 15, 15, 15. gry_cnt holds at 1000. tc = 1 in each of the cycles after a step from 15.
- ld=1, ld_bin=5, clr=1, en=1 in the same cycle at bin_cnt=9 → bin_cnt = 0, gry_cnt = 0000, tc = 0. The next cycle with clr=0, ld=1 gives bin_cnt = 5, gry_cnt = 0111.
- INIT=6, rst pulsed asynchronously between edges while bin_cnt = 11 → bin_cnt = 6 and gry_cnt = 0101 before the next edge. Counting resumes from 6 after release.
- Random en, dir, ld and clr for 10k cycles → a scoreboard confirms gry_cnt == bin ^ (bin >> 1) every cycle. It also confirms a single-bit Gray change on every non-saturating step, and that tc matches the reference model.
